// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Two-port (core/loader) arbiter sequencing a fixed-latency memory.
//            Define MEM_ARB_CORE_PRIORITY_EN for fixed core priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_c,
  input  logic          we_c,
  input  logic [AW-1:0] addr_c,
  input  logic [DW-1:0] wdata_c,
  input  logic          req_l,
  input  logic          we_l,
  input  logic [AW-1:0] addr_l,
  input  logic [DW-1:0] wdata_l,
  output logic          gnt_c,
  output logic          gnt_l,
  output logic          rdy_c,
  output logic          rdy_l,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] c_lat    = 4'(MEM_LAT);
  localparam logic       c_port_c = 1'b0;
  localparam logic       c_port_l = 1'b1;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            own_q, own_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            w_pick_l;

`ifdef MEM_ARB_CORE_PRIORITY_EN
  assign w_pick_l = req_l & ~req_c;
`else
  // Loader wins a tie only when the core was served last.
  assign w_pick_l = req_l & (~req_c | (last_q == c_port_c));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    own_d   = own_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_c || req_l) begin
          own_d   = w_pick_l ? c_port_l : c_port_c;
          last_d  = w_pick_l ? c_port_l : c_port_c;
          we_d    = w_pick_l ? we_l     : we_c;
          addr_d  = w_pick_l ? addr_l   : addr_c;
          wdata_d = w_pick_l ? wdata_l  : wdata_c;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 4'd1;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == c_lat) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= c_port_l;
      own_q   <= c_port_c;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      own_q   <= own_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign gnt_c     = busy && (own_q == c_port_c);
  assign gnt_l     = busy && (own_q == c_port_l);
  assign rdy_c     = (state_q == DONE) && (own_q == c_port_c);
  assign rdy_l     = (state_q == DONE) && (own_q == c_port_l);
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter (MEM_LAT = 2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_c = 1'b0, we_c = 1'b0, req_l = 1'b0, we_l = 1'b0;
  logic [31:0] addr_c = '0, wdata_c = '0, addr_l = '0, wdata_l = '0;
  logic        gnt_c, gnt_l, rdy_c, rdy_l, busy, mem_en, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] rd_p1 = '0;
  logic [31:0] tmem [0:255];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_c(req_c), .we_c(we_c), .addr_c(addr_c), .wdata_c(wdata_c),
    .req_l(req_l), .we_l(we_l), .addr_l(addr_l), .wdata_l(wdata_l),
    .gnt_c(gnt_c), .gnt_l(gnt_l), .rdy_c(rdy_c), .rdy_l(rdy_l),
    .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory with two-cycle read latency after the mem_en cycle.
  always @(posedge clk) begin
    if (mem_en && mem_we) tmem[mem_addr[7:0]] <= mem_wdata;
    if (mem_en) rd_p1 <= tmem[mem_addr[7:0]];
    mem_rdata <= rd_p1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tmem[i] = 32'h0;
    tmem[8'h10] = 32'hDEAD_BEEF;

    // Reset state
    repeat (3) tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_gnt",  {30'b0, gnt_c, gnt_l}, 32'd0);
    check("rst_rdy",  {30'b0, rdy_c, rdy_l}, 32'd0);
    check("rst_mem",  {30'b0, mem_en, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    // Single core read: cycle 0 request
    tick();
    req_c = 1'b1; we_c = 1'b0; addr_c = 32'h10;
    tick();
    check("rd_en_addr", {mem_en, mem_we, gnt_c, gnt_l, mem_addr[27:0]}, {4'b1010, 28'h10});
    tick(); tick();
    check("rd_no_rdy_c3", {31'b0, rdy_c}, 32'd0);
    tick();
    check("rd_rdy_c4", {30'b0, rdy_c, rdy_l}, 32'd2);
    check("rd_rdata", rdata, 32'hDEAD_BEEF);
    req_c = 1'b0;
    tick();
    check("rd_busy_c5", {31'b0, busy}, 32'd0);

    // Loader write
    req_l = 1'b1; we_l = 1'b1; addr_l = 32'h20; wdata_l = 32'h1234_5678;
    tick();
    check("wr_en_we", {30'b0, mem_en, mem_we}, 32'd3);
    check("wr_wdata", mem_wdata, 32'h1234_5678);
    check("wr_addr_gnt", {gnt_c, gnt_l, mem_addr[29:0]}, {2'b01, 30'h20});
    addr_l = 32'h99; wdata_l = 32'h0;
    tick(); tick();
    check("wr_hold_addr", mem_addr, 32'h20);
    tick();
    check("wr_rdy_c4", {30'b0, rdy_c, rdy_l}, 32'd1);
    check("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
    req_l = 1'b0; we_l = 1'b0;
    tick();

    // Competing requests held high from reset
    do_reset();
    req_c = 1'b1; we_c = 1'b0; addr_c = 32'h10;
    req_l = 1'b1; we_l = 1'b1; addr_l = 32'h30; wdata_l = 32'hAAAA_5555;
    for (int c = 1; c <= 20; c++) begin
      logic exp_c, exp_l;
      tick();
`ifdef MEM_ARB_CORE_PRIORITY_EN
      exp_c = (c == 4) || (c == 9) || (c == 14);
      exp_l = (c == 19);
`else
      exp_c = (c == 4) || (c == 14);
      exp_l = (c == 9) || (c == 19);
`endif
      check($sformatf("arb_c%0d", c), {29'b0, gnt_c & gnt_l, rdy_c, rdy_l},
            {29'b0, 1'b0, exp_c, exp_l});
      if (c == 14) req_c = 1'b0;
      if (c == 19) begin req_l = 1'b0; we_l = 1'b0; end
    end

    // Loader request raised during a core WAIT
    do_reset();
    req_c = 1'b1; we_c = 1'b0; addr_c = 32'h10;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 2) begin req_l = 1'b1; we_l = 1'b1; addr_l = 32'h40; wdata_l = 32'h0BAD_F00D; end
      if (c >= 2 && c <= 6)
        check($sformatf("late_en_c%0d", c), {31'b0, mem_en}, {31'b0, c == 6});
      if (c == 4) req_c = 1'b0;
      if (c == 6) check("late_addr", mem_addr, 32'h40);
      if (c == 9) begin
        check("late_rdy_l", {30'b0, rdy_c, rdy_l}, 32'd1);
        req_l = 1'b0; we_l = 1'b0;
      end
    end
    tick();

    // Reset during WAIT (rdata still holds 0xDEADBEEF here)
    req_c = 1'b1; we_c = 1'b0; addr_c = 32'h10;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wrst_busy_gnt", {29'b0, busy, gnt_c, gnt_l}, 32'd0);
    check("wrst_rdy_en", {28'b0, rdy_c, rdy_l, mem_en, mem_we}, 32'd0);
    check("wrst_rdata", rdata, 32'd0);
    check("wrst_addr", mem_addr, 32'd0);
    tick();
    check("wrst_reissue", {mem_en, gnt_c, mem_addr[29:0]}, {2'b11, 30'h10});
    tick(); tick();
    check("wrst_no_early_rdy", {31'b0, rdy_c}, 32'd0);
    tick();
    check("wrst_rdy_c", {30'b0, rdy_c, rdy_l}, 32'd2);
    check("wrst_rdata_new", rdata, 32'hDEAD_BEEF);
    req_c = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
